register: RTL and testbench

Parameterised N-bit storage register with asynchronous active-low clear and an active-low load select. It is the basic state element of the TD4-style CPU datapath: the general registers, output port latch and similar state are instances of it, each loading from a shared data bus when its select is asserted on a rising clock edge.

---
 rtl/register_pkg.sv | 5 +
 rtl/register.sv | 25 ++
 tb/tb_register.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/register_pkg.sv
// Shared constants for the TD4-style datapath state elements.
// Only the default storage width lives here; each instance may override it.
package register_pkg;
    localparam int REG_WIDTH = 4;
endpackage

// File: rtl/register.sv
// N-bit storage register with asynchronous active-low clear and active-low load select.
// Used for the general registers and the output port latch, loading from the shared data bus.
module register
    import register_pkg::*;
#(
    parameter int                  bitWidth   = REG_WIDTH,
    parameter logic [bitWidth-1:0] resetValue = '0
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CS,
    input  logic [bitWidth-1:0] D,
    output logic [bitWidth-1:0] Q
);

    // Clear wins over select; Q comes straight from the flops, so there is no D-to-Q path.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q <= resetValue;
        end else if (!CS) begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for register: default 4-bit instance plus an 8-bit
// instance with a non-zero clear value.
`timescale 1ns/1ps
module tb_register;

    logic       clk;
    logic       clr;
    logic       cs;
    logic [3:0] d;
    logic [3:0] q;

    logic       clr8;
    logic       cs8;
    logic [7:0] d8;
    logic [7:0] q8;

    int passed;
    int total;

    register dut (
        .CLK(clk),
        .CLR(clr),
        .CS (cs),
        .D  (d),
        .Q  (q)
    );

    register #(
        .bitWidth  (8),
        .resetValue(8'h80)
    ) dut8 (
        .CLK(clk),
        .CLR(clr8),
        .CS (cs8),
        .D  (d8),
        .Q  (q8)
    );

    // 1 us clock period
    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] exp);
        total++;
        if (q !== exp) $display("[TB] FAIL %s: Q=%h expected %h", name, q, exp);
        else passed++;
    endtask

    task automatic check8(input string name, input logic [7:0] exp);
        total++;
        if (q8 !== exp) $display("[TB] FAIL %s: Q=%h expected %h", name, q8, exp);
        else passed++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        cs  = 1'b1;
        d   = 4'h0;
        clr = 1'b0;
        #1;
        check4("reset_async", 4'h0);
        @(posedge clk); #1;
        check4("reset_during_edge", 4'h0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        check4("reset_after_release", 4'h0);
    endtask

    task automatic test_hold();
        @(negedge clk);
        d  = 4'hF;
        cs = 1'b1;
        @(posedge clk); #1;
        check4("hold_edge1", 4'h0);
        @(posedge clk); #1;
        check4("hold_edge2", 4'h0);
    endtask

    task automatic test_load();
        @(negedge clk);
        d  = 4'hF;
        cs = 1'b0;
        @(posedge clk); #1;
        check4("load_F", 4'hF);
        @(negedge clk);
        check4("load_F_stable", 4'hF);
        cs = 1'b1;
        d  = 4'h3;
        @(posedge clk); #1;
        check4("load_hold1", 4'hF);
        @(posedge clk); #1;
        check4("load_hold2", 4'hF);
    endtask

    task automatic test_clear_priority();
        @(negedge clk);
        d  = 4'hA;
        cs = 1'b0;
        @(posedge clk); #1;
        check4("prio_preload_A", 4'hA);
        @(negedge clk);
        d = 4'h5;
        #200;
        clr = 1'b0;
        #1;
        check4("prio_async_clear", 4'h0);
        @(posedge clk); #1;
        check4("prio_clear_beats_cs", 4'h0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        check4("prio_load_after_release", 4'h5);
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [3] = '{4'h1, 4'h2, 4'h3};
        cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d = vals[i];
            @(posedge clk); #1;
            check4($sformatf("b2b_%0d", i), vals[i]);
        end
        @(negedge clk);
        cs = 1'b1;
    endtask

    task automatic test_params();
        @(negedge clk);
        cs8  = 1'b1;
        d8   = 8'h00;
        clr8 = 1'b0;
        #1;
        check8("param_clear", 8'h80);
        @(negedge clk);
        clr8 = 1'b1;
        @(posedge clk); #1;
        check8("param_after_release", 8'h80);
        @(negedge clk);
        d8  = 8'hFF;
        cs8 = 1'b0;
        @(posedge clk); #1;
        check8("param_load_FF", 8'hFF);
        @(negedge clk);
        cs8 = 1'b1;
        d8  = 8'h12;
        @(posedge clk); #1;
        check8("param_hold", 8'hFF);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clr    = 1'b1;
        cs     = 1'b1;
        d      = 4'h0;
        clr8   = 1'b0;
        cs8    = 1'b1;
        d8     = 8'h00;
        test_reset();
        test_hold();
        test_load();
        test_clear_priority();
        test_back_to_back();
        test_params();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
